// File: rtl/plic_gateway.sv
// Per-source interrupt gateway in front of the PLIC core: synchronizes raw lines,
// counts edge events, and allows one outstanding request per source until claim+complete.
module plic_gateway #(
  parameter int                 NUM_SRC     = 10,
  parameter logic [NUM_SRC:1]   EDGE_MASK   = '0,
  parameter int                 MAX_PEND    = 7,
  parameter int                 SYNC_STAGES = 2
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [NUM_SRC:1]   IrqIn,
  input  logic               ClaimValid,
  input  logic [5:0]         ClaimID,
  input  logic               CompleteValid,
  input  logic [5:0]         CompleteID,
  input  logic               OvfClr,
  output logic [NUM_SRC:1]   Requests,
  output logic [NUM_SRC:1]   Overflow
);

  localparam int              CW     = $clog2(MAX_PEND + 1);
  localparam logic [CW-1:0]   CntMax = CW'(MAX_PEND);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    INFLIGHT = 2'd2
  } state_e;

  logic [NUM_SRC:1] syncQ [SYNC_STAGES];
  logic [NUM_SRC:1] prevQ;
  logic [NUM_SRC:1] syncLvl;
  logic [NUM_SRC:1] edgeDet;
  logic [NUM_SRC:1] claimHit;
  logic [NUM_SRC:1] compHit;

  state_e           stateQ [1:NUM_SRC];
  state_e           stateD [1:NUM_SRC];
  logic [CW-1:0]    cntQ   [1:NUM_SRC];
  logic [CW-1:0]    cntD   [1:NUM_SRC];
  logic [NUM_SRC:1] ovfQ;
  logic [NUM_SRC:1] ovfD;
  logic [NUM_SRC:1] ovfSet;

  assign syncLvl = syncQ[SYNC_STAGES-1];
  assign edgeDet = syncLvl & ~prevQ;

  // IDs 0 and above NUM_SRC never match any k, so they fall out as ignored.
  always_comb begin
    claimHit = '0;
    compHit  = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      claimHit[k] = ClaimValid    && (ClaimID    == 6'(k));
      compHit[k]  = CompleteValid && (CompleteID == 6'(k));
    end
  end

  always_comb begin
    ovfSet = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      stateD[k] = stateQ[k];
      cntD[k]   = cntQ[k];

      case (stateQ[k])
        IDLE: begin
          if (EDGE_MASK[k]) begin
            // cnt + edge - 1: a fresh edge consumed at once leaves cnt as is.
            if (edgeDet[k] || (cntQ[k] != '0)) begin
              stateD[k] = REQ;
              if (!edgeDet[k]) begin
                cntD[k] = cntQ[k] - CW'(1);
              end
            end
          end else if (syncLvl[k]) begin
            stateD[k] = REQ;
          end
        end
        REQ: begin
          if (claimHit[k]) begin
            stateD[k] = INFLIGHT;
          end
        end
        INFLIGHT: begin
          if (compHit[k]) begin
            stateD[k] = IDLE;
          end
        end
        default: stateD[k] = IDLE;
      endcase

      if (EDGE_MASK[k] && (stateQ[k] != IDLE) && edgeDet[k]) begin
        if (cntQ[k] == CntMax) begin
          ovfSet[k] = 1'b1;
        end else begin
          cntD[k] = cntQ[k] + CW'(1);
        end
      end
    end
  end

  // A saturating edge in the same cycle as OvfClr keeps the flag set.
  assign ovfD = (ovfQ & ~{NUM_SRC{OvfClr}}) | ovfSet;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        syncQ[i] <= '0;
      end
      prevQ <= '0;
    end else begin
      syncQ[0] <= IrqIn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        syncQ[i] <= syncQ[i-1];
      end
      prevQ <= syncLvl;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        stateQ[k] <= IDLE;
        cntQ[k]   <= '0;
      end
      ovfQ <= '0;
    end else begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        stateQ[k] <= stateD[k];
        cntQ[k]   <= cntD[k];
      end
      ovfQ <= ovfD;
    end
  end

  always_comb begin
    Requests = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      Requests[k] = (stateQ[k] == REQ);
    end
  end

  assign Overflow = ovfQ;

endmodule

// File: tb/tb_plic_gateway.sv
// Randomized and directed bench for plic_gateway against a per-source behavioural model.
module tb_plic_gateway;

  localparam int               NUM_SRC     = 10;
  localparam logic [NUM_SRC:1] EDGE_MASK   = 10'h306;
  localparam int               MAX_PEND    = 7;
  localparam int               SYNC_STAGES = 2;

  logic               PCLK;
  logic               PRESETn;
  logic [NUM_SRC:1]   IrqIn;
  logic               ClaimValid;
  logic [5:0]         ClaimID;
  logic               CompleteValid;
  logic [5:0]         CompleteID;
  logic               OvfClr;
  logic [NUM_SRC:1]   Requests;
  logic [NUM_SRC:1]   Overflow;

  int testCount = 0;
  int failCount = 0;
  int reqSeen;

  // Model: a source is idle, requesting, or waiting on completion; edges pile up in a count.
  bit               mReq  [1:NUM_SRC];
  bit               mBusy [1:NUM_SRC];
  int               mCnt  [1:NUM_SRC];
  bit               mOvf  [1:NUM_SRC];
  logic [NUM_SRC:1] pipe [$];
  logic [NUM_SRC:1] mPrevS;

  plic_gateway #(
    .NUM_SRC    (NUM_SRC),
    .EDGE_MASK  (EDGE_MASK),
    .MAX_PEND   (MAX_PEND),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .IrqIn        (IrqIn),
    .ClaimValid   (ClaimValid),
    .ClaimID      (ClaimID),
    .CompleteValid(CompleteValid),
    .CompleteID   (CompleteID),
    .OvfClr       (OvfClr),
    .Requests     (Requests),
    .Overflow     (Overflow)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    pipe.delete();
    for (int i = 0; i < SYNC_STAGES; i++) pipe.push_back('0);
    mPrevS = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      mReq[k] = 0; mBusy[k] = 0; mCnt[k] = 0; mOvf[k] = 0;
    end
  endtask

  task automatic modelStep();
    logic [NUM_SRC:1] sNow;
    logic [NUM_SRC:1] rise;
    sNow = pipe[0];
    pipe.push_back(IrqIn);
    void'(pipe.pop_front());
    rise = sNow & ~mPrevS;
    mPrevS = sNow;
    for (int k = 1; k <= NUM_SRC; k++) begin
      bit ch, cp, sat;
      ch  = ClaimValid && (ClaimID == 6'(k));
      cp  = CompleteValid && (CompleteID == 6'(k));
      sat = 0;
      if (!mReq[k] && !mBusy[k]) begin
        if (EDGE_MASK[k]) begin
          if (rise[k] || mCnt[k] > 0) begin
            mReq[k] = 1;
            mCnt[k] = mCnt[k] + int'(rise[k]) - 1;
            if (mCnt[k] < 0) mCnt[k] = 0;
          end
        end else if (sNow[k]) begin
          mReq[k] = 1;
        end
      end else begin
        if (mReq[k] && ch) begin
          mReq[k] = 0; mBusy[k] = 1;
        end else if (mBusy[k] && cp) begin
          mBusy[k] = 0;
        end
        if (EDGE_MASK[k] && rise[k]) begin
          if (mCnt[k] == MAX_PEND) sat = 1;
          else mCnt[k]++;
        end
      end
      if (sat) mOvf[k] = 1;
      else if (OvfClr) mOvf[k] = 0;
    end
  endtask

  function automatic logic [NUM_SRC:1] reqVec();
    logic [NUM_SRC:1] r;
    for (int k = 1; k <= NUM_SRC; k++) r[k] = mReq[k];
    return r;
  endfunction

  function automatic logic [NUM_SRC:1] ovfVec();
    logic [NUM_SRC:1] r;
    for (int k = 1; k <= NUM_SRC; k++) r[k] = mOvf[k];
    return r;
  endfunction

  task automatic applyStimulus();
    @(posedge PCLK);
    modelStep();
    #1;
    checkOutput("requests", 64'(Requests), 64'(reqVec()));
    checkOutput("overflow", 64'(Overflow), 64'(ovfVec()));
    ClaimValid    = 1'b0;
    CompleteValid = 1'b0;
    OvfClr        = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus();
  endtask

  task automatic pulse(input int k);
    IrqIn[k] = 1'b1; applyStimulus();
    IrqIn[k] = 1'b0; applyStimulus();
  endtask

  task automatic claim(input int id);
    ClaimValid = 1'b1; ClaimID = 6'(id); applyStimulus();
  endtask

  task automatic complete(input int id);
    CompleteValid = 1'b1; CompleteID = 6'(id); applyStimulus();
  endtask

  task automatic doReset();
    #2;
    PRESETn = 1'b0;
    #1;
    checkOutput("asyncResetReq", 64'(Requests), 64'(0));
    checkOutput("asyncResetOvf", 64'(Overflow), 64'(0));
    @(posedge PCLK);
    #2;
    PRESETn = 1'b1;
    modelReset();
  endtask

  function automatic int pickSrc(input bit wantBusy);
    int start;
    start = $urandom_range(NUM_SRC - 1);
    for (int i = 0; i < NUM_SRC; i++) begin
      int k;
      k = ((start + i) % NUM_SRC) + 1;
      if (wantBusy ? mBusy[k] : mReq[k]) return k;
    end
    return 0;
  endfunction

  initial begin
    PRESETn = 1'b0; IrqIn = '0; ClaimValid = 1'b0; ClaimID = '0;
    CompleteValid = 1'b0; CompleteID = '0; OvfClr = 1'b0;
    modelReset();
    #12;
    checkOutput("resetReq", 64'(Requests), 64'(0));
    checkOutput("resetOvf", 64'(Overflow), 64'(0));
    PRESETn = 1'b1;

    // Level source 1: latency, claim, re-request after completion while still high.
    IrqIn[1] = 1'b1;
    idle(2);
    checkOutput("lvlEarly", 64'(Requests[1]), 64'(0));
    applyStimulus();
    checkOutput("lvlLatency", 64'(Requests[1]), 64'(1));
    claim(1);
    checkOutput("lvlClaimed", 64'(Requests[1]), 64'(0));
    complete(1);
    checkOutput("lvlCompleteIdle", 64'(Requests[1]), 64'(0));
    applyStimulus();
    checkOutput("lvlReRequest", 64'(Requests[1]), 64'(1));
    IrqIn[1] = 1'b0;
    claim(1); complete(1); idle(2);

    // Edge source 2: three edges queued while in flight yield exactly three more requests.
    pulse(2); applyStimulus();
    checkOutput("edgeLatency", 64'(Requests[2]), 64'(1));
    claim(2);
    repeat (3) pulse(2);
    idle(3);
    reqSeen = 0;
    repeat (5) begin
      complete(2);
      applyStimulus();
      if (Requests[2]) reqSeen++;
      if (mReq[2]) claim(2);
    end
    checkOutput("edgeReqCount", 64'(reqSeen), 64'(3));

    // Saturation and OvfClr race on source 2.
    pulse(2); applyStimulus(); claim(2);
    repeat (9) pulse(2);
    idle(3);
    checkOutput("ovfSet", 64'(Overflow[2]), 64'(1));
    IrqIn[2] = 1'b1; applyStimulus();
    IrqIn[2] = 1'b0; applyStimulus();
    OvfClr = 1'b1; applyStimulus();
    checkOutput("ovfClrRace", 64'(Overflow[2]), 64'(1));
    OvfClr = 1'b1; applyStimulus();
    checkOutput("ovfClrAlone", 64'(Overflow[2]), 64'(0));

    // Mismatched and illegal handshakes on level source 4.
    IrqIn[4] = 1'b1; idle(3);
    complete(4);
    checkOutput("cmpInReq", 64'(Requests[4]), 64'(1));
    claim(0);
    claim(63);
    checkOutput("illegalClaim", 64'(Requests[4]), 64'(1));
    claim(4); IrqIn[4] = 1'b0; complete(4); idle(1);

    // Same-ID claim and complete: only the claim lands.
    IrqIn[5] = 1'b1; idle(3);
    ClaimValid = 1'b1; ClaimID = 6'd5; CompleteValid = 1'b1; CompleteID = 6'd5;
    applyStimulus();
    idle(2);
    checkOutput("sameIdInflight", 64'(Requests[5]), 64'(0));
    IrqIn[5] = 1'b0; complete(5);

    // Claim of 6 and complete of 7 together.
    IrqIn[6] = 1'b1; IrqIn[7] = 1'b1; idle(3);
    claim(7);
    IrqIn[6] = 1'b0;
    ClaimValid = 1'b1; ClaimID = 6'd6; CompleteValid = 1'b1; CompleteID = 6'd7;
    applyStimulus();
    checkOutput("split6Claimed", 64'(Requests[6]), 64'(0));
    applyStimulus();
    checkOutput("split7Rerequest", 64'(Requests[7]), 64'(1));
    IrqIn[7] = 1'b0; claim(7); complete(7); complete(6);

    // Reset mid-flight: source 3 in flight with two counted edges, source 10 overflowed.
    pulse(3); applyStimulus(); claim(3);
    pulse(3); pulse(3);
    pulse(10); applyStimulus(); claim(10);
    repeat (8) pulse(10);
    idle(3);
    checkOutput("preResetOvf10", 64'(Overflow[10]), 64'(1));
    doReset();
    idle(10);
    checkOutput("postResetSrc3", 64'(Requests[3]), 64'(0));

    for (int n = 0; n < 1500; n++) begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        if ($urandom_range(7) == 0) IrqIn[k] = ~IrqIn[k];
      end
      if ($urandom_range(1) == 1) begin
        ClaimValid = 1'b1;
        ClaimID = ($urandom_range(3) == 0) ? 6'($urandom_range(63)) : 6'(pickSrc(0));
      end
      if ($urandom_range(1) == 1) begin
        CompleteValid = 1'b1;
        CompleteID = ($urandom_range(3) == 0) ? 6'($urandom_range(63)) : 6'(pickSrc(1));
      end
      OvfClr = ($urandom_range(15) == 0);
      applyStimulus();
      if ($urandom_range(499) == 0) doReset();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/plic_gateway.md
Name: plic_gateway

Overview:
- Per-source interrupt gateway, sits directly upstream of the PLIC core.
- Synchronizes raw peripheral interrupt lines (UART, GPIO, SPI, SDC, ...) into PCLK.
- Each source is level- or edge-triggered. Edge events are counted.
- Presents at most one outstanding request per source and holds off the next one until the core signals claim and then completion for that source ID.

Parameters:
- NUM_SRC, 10, number of sources (IDs 1..NUM_SRC, max 63); matches the core's PLIC_NUM_SRC.
- EDGE_MASK, 0, NUM_SRC-bit vector indexed [NUM_SRC:1]; bit=1 makes that source edge-triggered, 0 makes it level-triggered.
- MAX_PEND, 7, saturation value of the per-source edge counter (>=1). Counter width is clog2(MAX_PEND+1).
- SYNC_STAGES, 2, synchronizer depth on IrqIn (>=2).

Ports:
- PCLK  in  1  clock; all state updates on the rising edge.
- PRESETn  in  1  reset, asynchronous active-low; already decided, fixed polarity and synchronicity.
- IrqIn  in  NUM_SRC  raw asynchronous source lines, bit k = source ID k.
- ClaimValid  in  1  core claim pulse, one cycle.
- ClaimID  in  6  ID being claimed; qualified by ClaimValid.
- CompleteValid  in  1  core completion pulse, one cycle.
- CompleteID  in  6  ID being completed; qualified by CompleteValid.
- OvfClr  in  1  clears all Overflow bits.
- Requests  out  NUM_SRC  request to core, bit k = source k.
- Overflow  out  NUM_SRC  sticky edge-counter saturation flag per source.

Behaviour:
- Reset: while PRESETn=0, asynchronously clear everything.
  - Synchronizer flops and previous-value flops go to 0.
  - All source FSMs go to IDLE; all counters go to 0.
  - Requests=0 and Overflow=0.
  - Reset mid-operation drops in-flight and counted events silently. There is no replay.
- Sync:
  - s[k] is IrqIn[k] after SYNC_STAGES flops.
  - p[k] is s[k] delayed one cycle.
  - edge[k] = s[k] & ~p[k].
- Per-source FSM states:
  - IDLE: Requests[k]=0.
  - REQ: Requests[k]=1. Requests is decoded combinationally from the state register.
  - INFLIGHT: Requests[k]=0.
- Level source (EDGE_MASK[k]=0):
  - IDLE -> REQ when s[k]=1.
  - REQ -> INFLIGHT on a claim hit.
  - INFLIGHT -> IDLE on a complete hit.
  - In REQ, s[k] dropping to 0 does not withdraw the request.
  - After completion, s[k] is re-evaluated in IDLE. If still high, REQ is re-entered on the next edge.
- Edge source (EDGE_MASK[k]=1): counter cnt[k] records pending edges.
  - IDLE with (edge[k] | cnt[k]>0) -> REQ. cnt[k] updates to cnt[k] + edge[k] - 1, with no underflow.
  - In REQ or INFLIGHT, edge[k] increments cnt[k].
  - At cnt[k]=MAX_PEND, a further edge leaves cnt unchanged and sets Overflow[k].
  - Claim and completion transitions are the same as for level sources.
- Hit definitions:
  - Claim hit: ClaimValid & ClaimID==k.
  - Complete hit: CompleteValid & CompleteID==k.
- Latency: IrqIn[k] rises and is first sampled at edge 0. With SYNC_STAGES=2, Requests[k] is high after edge 2. This is the same for level and edge sources.
- Ignored events, with no state change:
  - Claim hit while in IDLE or INFLIGHT.
  - Complete hit while in IDLE or REQ.
  - ID 0, or ID > NUM_SRC, on either port.
- Simultaneous events:
  - Claim and complete for different IDs in the same cycle are applied independently.
  - Claim and complete for the same ID in the same cycle: only the claim is applied (REQ -> INFLIGHT); the complete is ignored.
  - Complete hit in INFLIGHT with a same-cycle edge: state -> IDLE and cnt increments. REQ is re-entered on the following edge.
- Overflow:
  - OvfClr clears all Overflow bits next edge.
  - A same-cycle saturating edge on source k wins: Overflow[k] stays 1.
- No combinational path from any input to Requests.

Test Plan:
- Reset mid-flight: source 3 in INFLIGHT with cnt=2, PRESETn low for 1 cycle -> Requests=0, Overflow=0 asynchronously; after reset, source 3 does not request again without a new edge.
- Level source 1, IrqIn[1] held high -> Requests[1]=1 after edge 2. ClaimID=1 -> Requests[1]=0. CompleteID=1 with IrqIn still high -> Requests[1]=1 again one cycle after completion.
- Edge source 2, three pulses while INFLIGHT (cnt=3) -> after each claim/complete pair, one REQ is issued. Exactly 3 further requests are seen, then Requests[2] stays 0.
- Saturation on source 2 (MAX_PEND=7): 9 edges while INFLIGHT -> cnt=7, Overflow[2]=1. OvfClr in the same cycle as a saturating edge -> Overflow[2] stays 1. OvfClr alone -> 0.
- Illegal and mismatched handshakes:
  - CompleteID=4 while source 4 is in REQ -> ignored, Requests[4] stays 1.
  - ClaimID=0 -> ignored.
  - ClaimID=63 with NUM_SRC=10 -> ignored, no state change.
- Same-cycle events:
  - ClaimID=5 and CompleteID=5 together with source 5 in REQ -> INFLIGHT.
  - Claim of 6 and complete of 7 in the same cycle -> both applied.
